// File: rtl/ysyx_22040125_dmem_resp.sv
// Data-memory responder: one outstanding load/store, a fixed LATENCY from accept to response,
// a 64-bit word array with byte-masked writes, and out-of-range error reporting.
module ysyx_22040125_dmem_resp #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);
    localparam int          DEPTH = 1 << DEPTH_LOG2;
    localparam logic [32:0] SPAN  = 33'd8 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wen_q, wen_d;
    logic [31:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wmask_q, wmask_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [63:0] mem [DEPTH];

    logic                  do_access;
    logic                  acc_wen;
    logic [31:0]           acc_addr;
    logic [63:0]           acc_wdata;
    logic [7:0]            acc_wmask;
    logic [31:0]           off;
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] idx;
    logic [63:0]           rd_word;
    logic                  mem_we;

    always_comb begin
        // With LATENCY=1 the access happens on the accepting edge, straight from the request inputs.
        if (state_q == IDLE) begin
            acc_wen   = req_wen;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_wmask = req_wmask;
        end else begin
            acc_wen   = wen_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_wmask = wmask_q;
        end
        off      = acc_addr - BASE_ADDR;
        in_range = (acc_addr >= BASE_ADDR) && ({1'b0, off} < SPAN);
        idx      = off[DEPTH_LOG2+2:3];
        rd_word  = mem[idx];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wen_d     = wen_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        do_access = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wen_d   = req_wen;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wmask_d = req_wmask;
                    if (LATENCY <= 1) begin
                        do_access = 1'b1;
                        state_d   = RESP;
                    end else begin
                        cnt_d   = 4'(LATENCY - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d     = 4'd0;
                    do_access = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (do_access) begin
            rdata_d = (in_range && !acc_wen) ? rd_word : 64'd0;
            err_d   = !in_range;
        end
        // A reset on the commit edge must drop the store.
        mem_we = do_access && acc_wen && in_range && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wen_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 64'd0;
            wmask_q <= 8'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 8; i++) begin
                if (acc_wmask[i]) mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

    assign req_ready  = (state_q == IDLE) && !rst;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_ysyx_22040125_dmem_resp.sv
// Directed bench: LATENCY=2 responder driven from a vector table plus hand sequences,
// and a LATENCY=1 instance for the back-to-back throughput pattern.
module tb_ysyx_22040125_dmem_resp;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_ready, req_wen = 1'b0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wmask = '0;
    logic        resp_valid, resp_ready = 1'b0, resp_err;
    logic [63:0] resp_rdata;

    logic        req_valid1 = 1'b0, req_ready1, req_wen1 = 1'b0;
    logic [31:0] req_addr1 = '0;
    logic [63:0] req_wdata1 = '0;
    logic [7:0]  req_wmask1 = '0;
    logic        resp_valid1, resp_ready1 = 1'b0, resp_err1;
    logic [63:0] resp_rdata1;

    ysyx_22040125_dmem_resp #(.LATENCY(2)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    ysyx_22040125_dmem_resp #(.LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_wen(req_wen1), .req_addr(req_addr1), .req_wdata(req_wdata1), .req_wmask(req_wmask1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_rdata(resp_rdata1), .resp_err(resp_err1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Full transaction on the LATENCY=2 instance; lat counts negedges from accept to resp_valid.
    task automatic xact(input logic wen, input logic [31:0] a, input logic [63:0] wd,
                        input logic [7:0] wm, output logic [63:0] rd, output logic er,
                        output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_wen = wen; req_addr = a; req_wdata = wd; req_wmask = wm;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
        end
        @(posedge clk); #1 req_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!resp_valid && lat < 20);
        rd = resp_rdata; er = resp_err;
        resp_ready = 1'b1;
        @(posedge clk); #1 resp_ready = 1'b0;
    endtask

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [63:0] rd;
        logic        er;
        int          lat;
        int          n;

        vecs[0]  = '{1'b1, 32'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 64'd0, 1'b0};
        vecs[1]  = '{1'b0, 32'h8000_0010, 64'd0, 8'h00, 64'h1122_3344_5566_7788, 1'b0};
        vecs[2]  = '{1'b1, 32'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 64'd0, 1'b0};
        vecs[3]  = '{1'b0, 32'h8000_0010, 64'd0, 8'h00, 64'h1122_3344_AAAA_AAAA, 1'b0};
        vecs[4]  = '{1'b1, 32'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'd0, 1'b0};
        vecs[5]  = '{1'b0, 32'h8000_0010, 64'd0, 8'h00, 64'h1122_3344_AAAA_AAAA, 1'b0};
        vecs[6]  = '{1'b1, 32'h8000_0000, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'd0, 1'b0};
        vecs[7]  = '{1'b1, 32'h8000_7FF8, 64'hFEDC_BA98_7654_3210, 8'hFF, 64'd0, 1'b0};
        vecs[8]  = '{1'b0, 32'h7FFF_FFF8, 64'd0, 8'h00, 64'd0, 1'b1};
        vecs[9]  = '{1'b0, 32'h8000_8000, 64'd0, 8'h00, 64'd0, 1'b1};
        vecs[10] = '{1'b1, 32'h7FFF_FFF8, 64'h5555_5555_5555_5555, 8'hFF, 64'd0, 1'b1};
        vecs[11] = '{1'b1, 32'h8000_8000, 64'h6666_6666_6666_6666, 8'hFF, 64'd0, 1'b1};
        vecs[12] = '{1'b0, 32'h8000_0000, 64'd0, 8'h00, 64'h0123_4567_89AB_CDEF, 1'b0};
        vecs[13] = '{1'b0, 32'h8000_7FF8, 64'd0, 8'h00, 64'hFEDC_BA98_7654_3210, 1'b0};
        vecs[14] = '{1'b0, 32'h8000_0017, 64'd0, 8'h00, 64'h1122_3344_AAAA_AAAA, 1'b0};
        vecs[15] = '{1'b1, 32'h8000_0020, 64'h0BAD_F00D_DEAD_BEEF, 8'hFF, 64'd0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", 64'(req_ready), 64'd1);
        chk("post_rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("post_rst_rdata", resp_rdata, 64'd0);
        chk("post_rst_err", 64'(resp_err), 64'd0);

        for (int i = 0; i < 16; i++) begin
            xact(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 64'(er), 64'(vecs[i].exp_err));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
        end

        // Backpressure: response held 5 cycles while a second request waits.
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0010;
        @(posedge clk); #1 req_addr = 32'h8000_0000;
        n = 0;
        do begin @(negedge clk); n++; end while (!resp_valid && n < 20);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_valid", k), 64'(resp_valid), 64'd1);
            chk($sformatf("bp%0d_rdata", k), resp_rdata, 64'h1122_3344_AAAA_AAAA);
            chk($sformatf("bp%0d_req_ready", k), 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1 resp_ready = 1'b0;
        @(negedge clk);
        chk("bp_after_hs_valid", 64'(resp_valid), 64'd0);
        chk("bp_after_hs_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        chk("bp_second_accepted", 64'(req_ready), 64'd0);
        n = 0;
        while (!resp_valid && n < 20) begin @(negedge clk); n++; end
        chk("bp_second_rdata", resp_rdata, 64'h0123_4567_89AB_CDEF);
        resp_ready = 1'b1;
        @(posedge clk); #1 resp_ready = 1'b0;

        // Reset while a store sits in WAIT: it must not commit.
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0020;
        req_wdata = 64'h1111_1111_1111_1111; req_wmask = 8'hFF;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wait_req_ready", 64'(req_ready), 64'd0);
        chk("rst_wait_resp_valid", 64'(resp_valid), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wait_after_ready", 64'(req_ready), 64'd1);
        chk("rst_wait_after_valid", 64'(resp_valid), 64'd0);
        xact(1'b0, 32'h8000_0020, 64'd0, 8'h00, rd, er, lat);
        chk("rst_wait_not_committed", rd, 64'h0BAD_F00D_DEAD_BEEF);

        // Reset while a store sits in RESP: it stays committed.
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0028;
        req_wdata = 64'h2222_3333_4444_5555; req_wmask = 8'hFF;
        @(posedge clk); #1 req_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!resp_valid && n < 20);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_resp_after_valid", 64'(resp_valid), 64'd0);
        xact(1'b0, 32'h8000_0028, 64'd0, 8'h00, rd, er, lat);
        chk("rst_resp_committed", rd, 64'h2222_3333_4444_5555);

        // LATENCY=1 back-to-back: req_ready and resp_valid alternate.
        @(negedge clk);
        req_valid1 = 1'b1; req_wen1 = 1'b1; req_addr1 = 32'h8000_0040;
        req_wdata1 = 64'h7777_8888_9999_0000; req_wmask1 = 8'hFF; resp_ready1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("l1_c%0d_req_ready", k), 64'(req_ready1), 64'((k % 2) == 0));
            chk($sformatf("l1_c%0d_resp_valid", k), 64'(resp_valid1), 64'((k % 2) == 1));
            @(negedge clk);
        end
        req_wen1 = 1'b0;
        @(negedge clk);
        req_valid1 = 1'b0;
        chk("l1_load_valid", 64'(resp_valid1), 64'd1);
        chk("l1_load_rdata", resp_rdata1, 64'h7777_8888_9999_0000);
        chk("l1_load_err", 64'(resp_err1), 64'd0);
        @(negedge clk);
        resp_ready1 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
